cntdown_mmss: RTL and testbench

Preset mm:ss countdown timer for the DE0 clock design. It counts down from a loaded BCD preset (00:00–59:59) to 00:00, one step per 1 Hz `cnten` tick, using cascaded mod-60 BCD down stages with borrow. It sits beside the up-counting minute/second chain, shares the same `cnten` tick and feeds the same 7-segment digit path. It reports expiry through a one-cycle `done` pulse and an optional alarm level.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/dcnt60.sv | 52 +++++
 rtl/cntdown_mmss.sv | 140 ++++++++++++++
 tb/tb_cntdown_mmss.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the DE0 clock counters: countdown state encoding,
// BCD digit limits and the preset clamp helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } cd_state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;

  // Out-of-range preset digits saturate rather than wrap.
  function automatic logic [3:0] clamp_units(input logic [3:0] d);
    return (d > UNITS_MAX) ? UNITS_MAX : d;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] d);
    return (d > TENS_MAX) ? TENS_MAX : d;
  endfunction

endpackage

// File: rtl/dcnt60.sv
// One mod-60 BCD down stage (tens 0-5, units 0-9) with preset load and
// borrow-out. bo is combinational so stages cascade within one cycle.
module dcnt60
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       load,
  input  logic [2:0] pre_tens,
  input  logic [3:0] pre_units,
  output logic [2:0] tens,
  output logic [3:0] units,
  output logic       bo
);

  logic [2:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  // Load has priority over decrement; decrement wraps 00 -> 59.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      tens_d  = clamp_tens(pre_tens);
      units_d = clamp_units(pre_units);
    end else if (dec) begin
      if (units_q == 4'd0) begin
        units_d = UNITS_MAX;
        tens_d  = (tens_q == 3'd0) ? TENS_MAX : tens_q - 3'd1;
      end else begin
        units_d = units_q - 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q  <= 3'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign bo    = dec && (tens_q == 3'd0) && (units_q == 4'd0);

endmodule

// File: rtl/cntdown_mmss.sv
// Preset mm:ss countdown timer. Optional alarm level is built only when
// CNTDOWN_ALARM_EN is defined; otherwise alarm is tied low.
//
//   state      | meaning
//   -----------+------------------------------------------
//   ST_IDLE    | count loaded/held, waiting for start
//   ST_RUN     | decrementing once per cnten tick
//   ST_PAUSE   | count held, start resumes
//   ST_EXPIRED | reached 00:00, holds until stop or load
module cntdown_mmss
  import clock_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cnten,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] pre_minup,
  input  logic [3:0] pre_minlow,
  input  logic [2:0] pre_secup,
  input  logic [3:0] pre_seclow,
  output logic [2:0] minup,
  output logic [3:0] minlow,
  output logic [2:0] secup,
  output logic [3:0] seclow,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  cd_state_e state_q, state_d;
  logic      done_q, done_d;
  logic      sec_dec, sec_bo, min_bo_unused;
  logic      cnt_zero, cnt_one;

  dcnt60 u_sec (
    .clk       (CLK),
    .rst       (RST),
    .dec       (sec_dec),
    .load      (load),
    .pre_tens  (pre_secup),
    .pre_units (pre_seclow),
    .tens      (secup),
    .units     (seclow),
    .bo        (sec_bo)
  );

  dcnt60 u_min (
    .clk       (CLK),
    .rst       (RST),
    .dec       (sec_bo),
    .load      (load),
    .pre_tens  (pre_minup),
    .pre_units (pre_minlow),
    .tens      (minup),
    .units     (minlow),
    .bo        (min_bo_unused)
  );

  assign cnt_zero = (minup == 3'd0) && (minlow == 4'd0) && (secup == 3'd0) && (seclow == 4'd0);
  assign cnt_one  = (minup == 3'd0) && (minlow == 4'd0) && (secup == 3'd0) && (seclow == 4'd1);

  // Next state with priority load > stop > start > cnten.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    sec_dec = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN)          state_d = ST_PAUSE;
      else if (state_q == ST_EXPIRED) state_d = ST_IDLE;
    end else if (start && state_q == ST_IDLE) begin
      if (!cnt_zero) state_d = ST_RUN;
    end else if (start && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (cnten && state_q == ST_RUN) begin
      sec_dec = 1'b1;
      if (cnt_one) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  // State and expiry pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = done_q;

`ifdef CNTDOWN_ALARM_EN
  logic       alarm_q, alarm_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;

  // Alarm rises with done and falls after ALARM_TICKS ticks spent in EXPIRED.
  always_comb begin
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    if (load || (stop && state_q == ST_EXPIRED)) begin
      alarm_d = 1'b0;
    end else if (done_d) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = 8'd0;
    end else if (alarm_q && state_q == ST_EXPIRED && cnten && !start) begin
      alarm_cnt_d = alarm_cnt_q + 8'd1;
      if (alarm_cnt_d == 8'(ALARM_TICKS)) alarm_d = 1'b0;
    end
  end

  // Alarm level and tick counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_ticks;
  assign unused_alarm_ticks = ^(8'(ALARM_TICKS));
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_cntdown_mmss.sv
// Directed bench for cntdown_mmss; alarm expectations follow CNTDOWN_ALARM_EN.
module tb_cntdown_mmss;
  import clock_pkg::*;

`ifdef CNTDOWN_ALARM_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, cnten, load, start, stop;
  logic [2:0] pre_minup, pre_secup, minup, secup;
  logic [3:0] pre_minlow, pre_seclow, minlow, seclow;
  logic       running, done, alarm;

  int total = 0;
  int bad   = 0;

  cntdown_mmss #(.ALARM_TICKS(3)) dut (
    .CLK(CLK), .RST(RST), .cnten(cnten), .load(load), .start(start), .stop(stop),
    .pre_minup(pre_minup), .pre_minlow(pre_minlow),
    .pre_secup(pre_secup), .pre_seclow(pre_seclow),
    .minup(minup), .minlow(minlow), .secup(secup), .seclow(seclow),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {1'b0, minup, minlow, 1'b0, secup, seclow};
  endfunction

  function automatic logic [15:0] st();
    return {14'd0, dut.state_q};
  endfunction

  task automatic pre(input logic [2:0] m1, input logic [3:0] m0, input logic [2:0] s1, input logic [3:0] s0);
    pre_minup = m1; pre_minlow = m0; pre_secup = s1; pre_seclow = s0;
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic cyc(input logic ld, input logic sa, input logic sp, input logic ce);
    load = ld; start = sa; stop = sp; cnten = ce;
    @(posedge CLK); #1;
    load = 0; start = 0; stop = 0; cnten = 0;
  endtask

  initial begin
    RST = 1; cnten = 0; load = 0; start = 0; stop = 0;
    pre(0, 0, 0, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 0;
    chk("rst_digits", digits(), 16'h0000);
    chk("rst_state", st(), 16'(ST_IDLE));
    chk("rst_flags", {13'd0, running, done, alarm}, 16'd0);

    // Borrow chain
    pre(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("load_1000", digits(), 16'h1000);
    cyc(0, 1, 0, 0);
    chk("start_running", {15'd0, running}, 16'd1);
    cyc(0, 0, 0, 1);
    chk("borrow_1000", digits(), 16'h0959);
    pre(0, 1, 0, 0); cyc(1, 0, 0, 0);
    chk("load_in_run_state", st(), 16'(ST_IDLE));
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    chk("borrow_0100", digits(), 16'h0059);

    // Preset clamp and zero start
    pre(7, 15, 7, 15); cyc(1, 0, 0, 0);
    chk("clamp_5959", digits(), 16'h5959);
    pre(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    chk("start_zero_idle", st(), 16'(ST_IDLE));

    // Pause and priority
    pre(0, 5, 3, 1); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    chk("run_0530", digits(), 16'h0530);
    cyc(0, 0, 1, 1);
    chk("stop_cnten_hold", digits(), 16'h0530);
    chk("stop_cnten_pause", st(), 16'(ST_PAUSE));
    cyc(0, 1, 1, 0);
    chk("start_stop_pause", st(), 16'(ST_PAUSE));
    cyc(0, 1, 0, 0);
    chk("resume_run", st(), 16'(ST_RUN));

    // Load in RUN
    pre(0, 2, 0, 0); cyc(1, 0, 0, 1);
    chk("load_run_digits", digits(), 16'h0200);
    chk("load_run_idle", st(), 16'(ST_IDLE));

    // Expiry with start+cnten in IDLE first
    pre(0, 0, 0, 2); cyc(1, 0, 0, 0); cyc(0, 1, 0, 1);
    chk("start_cnten_nodec", digits(), 16'h0002);
    cyc(0, 0, 0, 1);
    chk("dec_0001", digits(), 16'h0001);
    chk("no_early_done", {15'd0, done}, 16'd0);
    cyc(0, 0, 0, 1);
    chk("expire_digits", digits(), 16'h0000);
    chk("expire_done", {15'd0, done}, 16'd1);
    chk("expire_state", st(), 16'(ST_EXPIRED));
    chk("alarm_rise", {15'd0, alarm}, {15'd0, AL});
    cyc(0, 0, 0, 0);
    chk("done_one_cycle", {15'd0, done}, 16'd0);
    cyc(0, 0, 0, 1);
    chk("expired_hold", digits(), 16'h0000);
    chk("alarm_tick1", {15'd0, alarm}, {15'd0, AL});
    cyc(0, 0, 0, 1);
    chk("alarm_tick2", {15'd0, alarm}, {15'd0, AL});
    cyc(0, 0, 0, 1);
    chk("alarm_tick3_low", {15'd0, alarm}, 16'd0);
    chk("still_expired", st(), 16'(ST_EXPIRED));
    chk("no_done_later", {15'd0, done}, 16'd0);
    cyc(0, 1, 0, 0);
    chk("start_ignored", st(), 16'(ST_EXPIRED));
    cyc(0, 0, 1, 0);
    chk("stop_to_idle", st(), 16'(ST_IDLE));

    // Stop clears a live alarm
    pre(0, 0, 0, 1); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    chk("alarm_rise2", {15'd0, alarm}, {15'd0, AL});
    cyc(0, 0, 1, 0);
    chk("stop_clears_alarm", {15'd0, alarm}, 16'd0);

    // Reset mid-countdown
    pre(3, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
    chk("run_2959", digits(), 16'h2959);
    RST = 1; cyc(0, 0, 0, 1); RST = 0;
    chk("midrst_digits", digits(), 16'h0000);
    chk("midrst_state", st(), 16'(ST_IDLE));
    chk("midrst_flags", {13'd0, running, done, alarm}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
